// File: rtl/hazard_forward_ctrl_if.sv
// Hazard/forwarding control bundle between the decode/execute datapath and
// the hazard controller: D-stage decode info in, forward selects and stall/flush out.
interface hazard_forward_ctrl_if;
   logic [4:0] Rs1D;
   logic [4:0] Rs2D;
   logic [4:0] RdD;
   logic       RegWriteD;
   logic       LoadD;
   logic       MultiCycleD;
   logic       BranchTakenE;
   logic [1:0] forward_op1E;
   logic [1:0] forward_op2E;
   logic       StallF;
   logic       StallD;
   logic       StallE;
   logic       FlushD;
   logic       FlushE;
   logic       mc_busy;

   modport master (
      output Rs1D, Rs2D, RdD, RegWriteD, LoadD, MultiCycleD, BranchTakenE,
      input  forward_op1E, forward_op2E, StallF, StallD, StallE, FlushD, FlushE, mc_busy
   );

   modport slave (
      input  Rs1D, Rs2D, RdD, RegWriteD, LoadD, MultiCycleD, BranchTakenE,
      output forward_op1E, forward_op2E, StallF, StallD, StallE, FlushD, FlushE, mc_busy
   );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Execute-stage forwarding selects plus load-use, branch and multi-cycle FU
// stall/flush generation, driven by a private E/M/W shadow of register IDs.
module hazard_forward_ctrl #(
   parameter int unsigned MC_LATENCY = 4,
   parameter int unsigned CNT_W      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   hazard_forward_ctrl_if.slave hz
);
   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} mc_state_e;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       regwrite;
      logic       load;
      logic       multicycle;
   } e_fields_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   e_fields_t        e_q, e_d;
   logic [4:0]       rd_m_q, rd_m_d, rd_w_q;
   logic             regwrite_m_q, regwrite_m_d, regwrite_w_q;
   mc_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             mc_stall_s, lw_stall_s, flush_e_s;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m, input logic rw_m,
                                          input logic [4:0] rd_w, input logic rw_w);
      if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         return 2'b10;
      end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         return 2'b01;
      end else begin
         return 2'b00;
      end
   endfunction

   // Multi-cycle stall: first E cycle from IDLE, then until the counter reaches one.
   always_comb begin
      mc_stall_s = 1'b0;
      case (state_q)
         IDLE:    mc_stall_s = e_q.multicycle;
         BUSY:    mc_stall_s = (cnt_q != CNT_ONE);
         default: mc_stall_s = 1'b0;
      endcase
   end

   // A wrong-path D instruction under a taken branch must not cause a load-use stall.
   assign lw_stall_s = e_q.load && e_q.regwrite && (e_q.rd != 5'd0) &&
                       ((e_q.rd == hz.Rs1D) || (e_q.rd == hz.Rs2D)) && !hz.BranchTakenE;
   assign flush_e_s  = (lw_stall_s || hz.BranchTakenE) && !mc_stall_s;

   // Next state of the E and M shadow stages.
   always_comb begin
      e_d          = e_q;
      rd_m_d       = e_q.rd;
      regwrite_m_d = e_q.regwrite;
      if (mc_stall_s) begin
         e_d          = e_q;
         rd_m_d       = 5'd0;
         regwrite_m_d = 1'b0;
      end else if (flush_e_s) begin
         e_d = '0;
      end else begin
         e_d = '{rs1: hz.Rs1D, rs2: hz.Rs2D, rd: hz.RdD, regwrite: hz.RegWriteD,
                 load: hz.LoadD, multicycle: hz.MultiCycleD};
      end
   end

   // Shadow pipeline registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q          <= '0;
         rd_m_q       <= 5'd0;
         regwrite_m_q <= 1'b0;
         rd_w_q       <= 5'd0;
         regwrite_w_q <= 1'b0;
      end else begin
         e_q          <= e_d;
         rd_m_q       <= rd_m_d;
         regwrite_m_q <= regwrite_m_d;
         rd_w_q       <= rd_m_q;
         regwrite_w_q <= regwrite_m_q;
      end
   end

   // Multi-cycle occupancy FSM; a new op arriving in E always starts from IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (e_q.multicycle) begin
                  cnt_q   <= CNT_LOAD;
                  state_q <= BUSY;
               end else begin
                  cnt_q   <= cnt_q;
                  state_q <= IDLE;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= BUSY;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign hz.forward_op1E = fwd_sel(e_q.rs1, rd_m_q, regwrite_m_q, rd_w_q, regwrite_w_q);
   assign hz.forward_op2E = fwd_sel(e_q.rs2, rd_m_q, regwrite_m_q, rd_w_q, regwrite_w_q);
   assign hz.StallF       = lw_stall_s || mc_stall_s;
   assign hz.StallD       = lw_stall_s || mc_stall_s;
   assign hz.StallE       = mc_stall_s;
   assign hz.FlushD       = hz.BranchTakenE;
   assign hz.FlushE       = flush_e_s;
   assign hz.mc_busy      = (state_q == BUSY);
endmodule
